// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as the effective address, drives a req/gnt/rvalid
// data-memory port, aligns store data, extends load data and reports access faults.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_zero_extnd_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic [1:0]  lsu_err_code_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, ERR} state_t;

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    state_t      state, state_next;
    logic [15:0] cnt;
    logic        cnt_clr;
    logic        cnt_hit;
    logic [1:0]  code_p0, code_next;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;
    logic [1:0]  size_p0;
    logic        wr_p0;
    logic        zext_p0;
    logic        misaligned;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] size, input logic [1:0] off,
                                           input logic zext, input logic [31:0] data);
        logic [31:0] s;
        s = data >> {off, 3'b000};
        case (size)
            2'b00:   return {{24{s[7] & ~zext}}, s[7:0]};
            2'b01:   return {{16{s[15] & ~zext}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign misaligned = (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
                        (lsu_size_i == 2'b11 && lsu_addr_i[1:0] != 2'b00);
    // The awaited event on the last permitted cycle still wins over the timeout.
    assign cnt_hit = (cnt == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state;
        code_next  = code_p0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (lsu_req_i) begin
                    if (misaligned) begin
                        state_next = ERR;
                        code_next  = CODE_MISALIGN;
                    end else if (lsu_size_i == 2'b10) begin
                        state_next = ERR;
                        code_next  = CODE_ILLEGAL;
                    end else begin
                        state_next = REQ;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_next = wr_p0 ? DONE : RSP;
                    cnt_clr    = 1'b1;
                end else if (cnt_hit) begin
                    state_next = ERR;
                    code_next  = CODE_TIMEOUT;
                end
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    state_next = DONE;
                end else if (cnt_hit) begin
                    state_next = ERR;
                    code_next  = CODE_TIMEOUT;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            code_p0     <= '0;
            lsu_rdata_o <= '0;
        end else begin
            state   <= state_next;
            code_p0 <= code_next;
            if (cnt_clr)
                cnt <= '0;
            else if (state == REQ || state == RSP)
                cnt <= cnt + 16'd1;
            if (state == RSP && mem_rvalid_i)
                lsu_rdata_o <= extend(size_p0, addr_p0[1:0], zext_p0, mem_rdata_i);
        end
    end

    // Request capture: the access attributes are frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == IDLE && lsu_req_i) begin
            addr_p0  <= lsu_addr_i;
            wr_p0    <= lsu_wr_i;
            size_p0  <= lsu_size_i;
            zext_p0  <= lsu_zero_extnd_i;
            be_p0    <= byte_enable(lsu_size_i, lsu_addr_i[1:0]);
            wdata_p0 <= replicate(lsu_size_i, lsu_wdata_i);
        end
    end

    assign lsu_busy_o     = (state != IDLE);
    assign lsu_done_o     = (state == DONE);
    assign lsu_err_o      = (state == ERR);
    assign lsu_err_code_o = lsu_err_o ? code_p0 : 2'b00;
    assign mem_req_o      = (state == REQ);
    assign mem_addr_o     = mem_req_o ? {addr_p0[31:2], 2'b00} : 32'd0;
    assign mem_wr_o       = mem_req_o & wr_p0;
    assign mem_be_o       = mem_req_o ? be_p0 : 4'b0000;
    assign mem_wdata_o    = mem_req_o ? wdata_p0 : 32'd0;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential memory-access stage directly downstream of the ALU; consumes the ALU result as the effective address for loads and stores.
- Aligns, masks and replicates store data, then drives a request/grant/response data-memory port.
- Sign- or zero-extends load data and returns it to writeback.
- Holds the core stalled while an access is outstanding and reports misaligned, illegal-size and timeout faults.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_gnt_i or mem_rvalid_i before aborting; legal range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- lsu_req_i  input  1  access request; sampled only in IDLE
- lsu_addr_i  input  32  effective address (ALU result)
- lsu_wr_i  input  1  1 = store, 0 = load
- lsu_size_i  input  2  00 byte, 01 half-word, 11 word, 10 illegal
- lsu_zero_extnd_i  input  1  1 = zero-extend load, 0 = sign-extend
- lsu_wdata_i  input  32  store data, right-aligned
- lsu_busy_o  output  1  stall; high from cycle after acceptance until done/err pulse
- lsu_done_o  output  1  one-cycle pulse on successful completion
- lsu_rdata_o  output  32  extended load data; valid while lsu_done_o is high for a load
- lsu_err_o  output  1  one-cycle pulse on fault
- lsu_err_code_o  output  2  01 misaligned, 10 illegal size, 11 timeout; valid with lsu_err_o
- mem_req_o  output  1  memory request; held until granted
- mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wr_o  output  1  write strobe qualifier
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  32  lane-replicated store data
- mem_gnt_i  input  1  request accepted this cycle
- mem_rvalid_i  input  1  read data valid (loads only)
- mem_rdata_i  input  32  read data

Behaviour:
- Reset (reset_n low at clk edge): state IDLE; every output 0, including lsu_rdata_o and the timeout counter. Reset mid-access abandons the access immediately; no done or err pulse.
- FSM states: IDLE, REQ, RSP, DONE, ERR.
- IDLE, lsu_req_i = 1: latch all inputs.
  - Misaligned (half with addr[0] = 1; word with addr[1:0] != 0): go to ERR, code 01.
  - lsu_size_i = 10: go to ERR, code 10.
  - Otherwise go to REQ.
  - A faulting access never raises mem_req_o.
- REQ:
  - mem_req_o = 1; mem_* outputs stay stable until grant.
  - On mem_gnt_i: a store goes to DONE; a load goes to RSP.
  - mem_req_o falls the cycle after grant.
- RSP:
  - On mem_rvalid_i: register the extended data into lsu_rdata_o, go to DONE.
  - mem_rvalid_i outside RSP is ignored.
- DONE: lsu_done_o = 1 for one cycle, then IDLE. ERR: lsu_err_o = 1 for one cycle, then IDLE.
- lsu_busy_o = 1 in REQ, RSP, DONE and ERR; 0 in IDLE. A new request may be accepted the cycle after a done/err pulse.
- Timeout:
  - Counter clears on entry to REQ and on entry to RSP; increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES without the awaited event goes to ERR, code 11; mem_req_o drops.
  - A grant or rvalid arriving in the same cycle the count is reached wins over the timeout.
- Byte enables (off = addr[1:0]):
  - byte: 1 << off
  - half: 0011 << off
  - word: 1111
- Store data: byte replicated to all four lanes; half replicated to both halves; word passed through.
- Load extract: shift mem_rdata_i right by 8*off, then keep the low 8, 16 or 32 bits. Bit 7 or bit 15 is replicated upward unless lsu_zero_extnd_i = 1. Word loads ignore lsu_zero_extnd_i.
- Latency, request accepted in cycle N:
  - mem_req_o high from N+1.
  - Grant at N+1: store done pulse at N+2.
  - Rvalid at N+2: load done pulse at N+3.
- lsu_req_i held high while busy has no effect.

Test Plan:
- Word store, addr 0x0000_1008, wdata 0xDEADBEEF, gnt at first req cycle -> mem_addr 0x1008, be 1111, wdata 0xDEADBEEF, mem_wr 1; done pulse 2 cycles after accept; busy high exactly 2 cycles.
- Byte load, signed, addr 0x103, mem_rdata 0x80xx_xxxx, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> be 1000, rdata 0xFFFF_FF80. Repeat with zero-extend -> 0x0000_0080.
- Half store, addr 0x102, wdata 0x0000_ABCD -> be 1100, wdata 0xABCD_ABCD. Half load, addr 0x102, rdata 0x7FFF_1234, signed -> 0x0000_7FFF.
- Misaligned word load, addr 0x101 -> no mem_req_o; err pulse with code 01 one cycle after accept. Same with size 10 at addr 0x100 -> code 10.
- TIMEOUT_CYCLES = 4, load never granted -> mem_req_o high 4 cycles, then err code 11; back in IDLE; next word load at addr 0x200 completes normally.
- reset_n low while in RSP -> next cycle all outputs 0, state IDLE; late mem_rvalid_i produces no done pulse.
